// File: rtl/sb_pattern_detect_if.sv
// Deserialized sideband RX word bus feeding the pattern detector.
interface sb_pattern_detect_if;
    logic [63:0] i_rx_word;
    logic        i_rx_word_valid;

    modport master (output i_rx_word, output i_rx_word_valid);
    modport slave  (input  i_rx_word, input  i_rx_word_valid);
endinterface

// File: rtl/sb_pattern_detect.sv
// Sideband RX clock-pattern detector: hunts for MATCH_TARGET consecutive
// PATTERN words and pulses o_rx_sb_pattern_samp_done once on success.
module sb_pattern_detect #(
    parameter logic [63:0] PATTERN      = 64'hAAAA_AAAA_AAAA_AAAA,
    parameter int unsigned MATCH_TARGET = 2,
    parameter int unsigned GAP_MAX      = 200
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_detect_en,
    sb_pattern_detect_if.slave        rx,
    output logic                      o_rx_sb_pattern_samp_done,
    output logic                      o_pattern_detected,
    output logic [2:0]                o_match_cnt,
    output logic [7:0]                o_mismatch_cnt,
    output logic                      o_gap_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HUNT  = 2'd1,
        MATCH = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] TARGET = 3'(MATCH_TARGET);
    localparam logic [7:0] GAP_LIM = 8'(GAP_MAX);

    state_t     r_state, w_state;
    logic [2:0] r_match_cnt, w_match_cnt;
    logic [7:0] r_mismatch_cnt, w_mismatch_cnt;
    logic [7:0] r_gap, w_gap;
    logic       r_done, w_done;
    logic       r_detected, w_detected;
    logic       r_timeout, w_timeout;
    logic       w_hit;
    logic [7:0] w_mismatch_inc;
    logic [2:0] w_match_inc;

    assign w_hit          = (rx.i_rx_word == PATTERN);
    assign w_mismatch_inc = (r_mismatch_cnt == 8'hFF) ? r_mismatch_cnt : r_mismatch_cnt + 8'd1;
    assign w_match_inc    = r_match_cnt + 3'd1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state        <= IDLE;
            r_match_cnt    <= '0;
            r_mismatch_cnt <= '0;
            r_gap          <= '0;
            r_done         <= 1'b0;
            r_detected     <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_match_cnt    <= w_match_cnt;
            r_mismatch_cnt <= w_mismatch_cnt;
            r_gap          <= w_gap;
            r_done         <= w_done;
            r_detected     <= w_detected;
            r_timeout      <= w_timeout;
        end
    end

    always_comb begin
        w_state        = r_state;
        w_match_cnt    = r_match_cnt;
        w_mismatch_cnt = r_mismatch_cnt;
        w_gap          = r_gap;
        w_done         = 1'b0;
        w_detected     = 1'b0;
        w_timeout      = 1'b0;

        // Disable wins over everything, including a final matching word.
        if (!i_detect_en) begin
            w_state     = IDLE;
            w_match_cnt = '0;
            w_gap       = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state        = HUNT;
                    w_mismatch_cnt = '0;
                end
                HUNT: begin
                    if (rx.i_rx_word_valid) begin
                        if (w_hit) begin
                            w_match_cnt = 3'd1;
                            if (TARGET == 3'd1) begin
                                w_state    = DONE;
                                w_done     = 1'b1;
                                w_detected = 1'b1;
                            end else begin
                                w_state = MATCH;
                            end
                        end else begin
                            w_mismatch_cnt = w_mismatch_inc;
                        end
                    end
                end
                MATCH: begin
                    if (rx.i_rx_word_valid) begin
                        w_gap = '0;
                        if (w_hit) begin
                            w_match_cnt = w_match_inc;
                            if (w_match_inc == TARGET) begin
                                w_state    = DONE;
                                w_done     = 1'b1;
                                w_detected = 1'b1;
                            end
                        end else begin
                            w_match_cnt    = '0;
                            w_mismatch_cnt = w_mismatch_inc;
                            w_state        = HUNT;
                        end
                    end else if (r_gap + 8'd1 == GAP_LIM) begin
                        w_match_cnt = '0;
                        w_gap       = '0;
                        w_timeout   = 1'b1;
                        w_state     = HUNT;
                    end else begin
                        w_gap = r_gap + 8'd1;
                    end
                end
                DONE: begin
                    w_detected = 1'b1;
                end
                default: w_state = IDLE;
            endcase
        end
    end

    assign o_rx_sb_pattern_samp_done = r_done;
    assign o_pattern_detected        = r_detected;
    assign o_match_cnt               = r_match_cnt;
    assign o_mismatch_cnt            = r_mismatch_cnt;
    assign o_gap_timeout             = r_timeout;

endmodule
